sdram_req_arbiter: RTL

Shares the single SDRAM command FSM between NUM_REQ independent requesters (e.g. AHB port, DMA, video fetch) and the refresh controller. Round-robin grant among requesters; refresh takes priority at transaction boundaries. A grant is held from command acceptance until the FSM signals completion. Sits between the request sources and sdram_cmd_fsm; the address mapper consumes cmd_addr_o.

---
 rtl/sdram_req_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter sharing one SDRAM command FSM between NUM_REQ requesters and refresh.
// Optional age promotion of starved requesters is enabled by defining SDRAM_ARB_AGE_PROMOTE_EN.
module sdram_req_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 64
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]            req_ack_o,
  output logic [NUM_REQ-1:0]            req_done_o,
  output logic                          cmd_valid_o,
  output logic                          cmd_write_o,
  output logic [ADDR_WIDTH-1:0]         cmd_addr_o,
  output logic [ID_WIDTH-1:0]           cmd_id_o,
  input  logic                          cmd_ready_i,
  input  logic                          cmd_done_i,
  input  logic                          refresh_req_i,
  output logic                          refresh_gnt_o,
  input  logic                          refresh_done_i,
  output logic                          busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_REFRESH} state_t;

  localparam logic [ID_WIDTH:0]   NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (2**ID_WIDTH) < NUM_REQ || MAX_WAIT < 1) begin : g_bad_cfg
    $error("sdram_req_arbiter: illegal parameter combination");
  end

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     rr_q, rr_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    rgnt_q, rgnt_d;
  logic                    busy_q, busy_d;

  logic                    accept;
  logic [2*NUM_REQ-1:0]    valid_dup;
  logic [NUM_REQ-1:0]      valid_rot;
  logic [ID_WIDTH-1:0]     rr_off;
  logic [ID_WIDTH:0]       rr_sum;
  logic [ID_WIDTH-1:0]     rr_id;
  logic [ID_WIDTH-1:0]     grant_id;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic                    sel_write;

  assign accept = (state_q == S_ISSUE) && cmd_valid_q && cmd_ready_i;

  // Rotating the doubled request vector by rr_q turns the wrap-around scan into a
  // plain lowest-set-bit search; the offset is then added back modulo NUM_REQ.
  assign valid_dup = {req_valid_i, req_valid_i};
  assign valid_rot = valid_dup[rr_q +: NUM_REQ];

  always_comb begin
    rr_off = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (valid_rot[i-1]) rr_off = ID_WIDTH'(i - 1);
    end
  end

  assign rr_sum = {1'b0, rr_q} + {1'b0, rr_off};
  assign rr_id  = (rr_sum >= NUM_REQ_W) ? ID_WIDTH'(rr_sum - NUM_REQ_W) : rr_sum[ID_WIDTH-1:0];

`ifdef SDRAM_ARB_AGE_PROMOTE_EN
  localparam int unsigned      AGE_W   = $clog2(MAX_WAIT) + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  logic [AGE_W-1:0]    age_q [NUM_REQ];
  logic [ID_WIDTH-1:0] promo_id;
  logic                promo_hit;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) age_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (accept && id_q == ID_WIDTH'(k)) begin
          age_q[k] <= '0;
        end else if (req_valid_i[k] && age_q[k] != AGE_MAX) begin
          age_q[k] <= age_q[k] + AGE_W'(1);
        end
      end
    end
  end

  always_comb begin
    promo_hit = 1'b0;
    promo_id  = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (req_valid_i[i-1] && age_q[i-1] == AGE_MAX) begin
        promo_hit = 1'b1;
        promo_id  = ID_WIDTH'(i - 1);
      end
    end
  end

  assign grant_id = promo_hit ? promo_id : rr_id;
`else
  assign grant_id = rr_id;
`endif

  always_comb begin
    sel_addr  = '0;
    sel_write = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_id == ID_WIDTH'(k)) begin
        sel_addr  = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_write = req_write_i[k];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    addr_d      = addr_q;
    write_d     = write_q;
    cmd_valid_d = cmd_valid_q;
    ack_d       = '0;
    done_d      = '0;
    rgnt_d      = rgnt_q;
    case (state_q)
      S_IDLE: begin
        if (refresh_req_i) begin
          state_d = S_REFRESH;
          rgnt_d  = 1'b1;
        end else if (|req_valid_i) begin
          state_d     = S_ISSUE;
          cmd_valid_d = 1'b1;
          id_d        = grant_id;
          addr_d      = sel_addr;
          write_d     = sel_write;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          state_d     = S_BUSY;
          cmd_valid_d = 1'b0;
          ack_d       = NUM_REQ'(1) << id_q;
        end
      end
      S_BUSY: begin
        if (cmd_done_i) begin
          state_d = S_IDLE;
          done_d  = NUM_REQ'(1) << id_q;
          rr_d    = (id_q == LAST_ID) ? '0 : id_q + ID_WIDTH'(1);
        end
      end
      S_REFRESH: begin
        if (refresh_done_i) begin
          state_d = S_IDLE;
          rgnt_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      ack_q       <= '0;
      done_q      <= '0;
      rgnt_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      cmd_valid_q <= cmd_valid_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      rgnt_q      <= rgnt_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ack_o     = ack_q;
  assign req_done_o    = done_q;
  assign cmd_valid_o   = cmd_valid_q;
  assign cmd_write_o   = write_q;
  assign cmd_addr_o    = addr_q;
  assign cmd_id_o      = id_q;
  assign refresh_gnt_o = rgnt_q;
  assign busy_o        = busy_q;

endmodule
